// File: rtl/mac_overlay_pkg.sv
// Shared definitions for the C3x3 27x27 SIMD MAC overlay: mode encodings,
// word widths and the per-mode lane geometry tables.
package mac_overlay_pkg;

    localparam int SUM_W   = 54;
    localparam int CARRY_W = 24;

    localparam logic [1:0] MODE_W54  = 2'd0;
    localparam logic [1:0] MODE_2X27 = 2'd1;
    localparam logic [1:0] MODE_3X18 = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // The reserved mode decodes as a single full-width lane.
    localparam int LANE_W_TAB [4] = '{54, 27, 18, 54};
    localparam int LANE_N_TAB [4] = '{1, 2, 3, 1};

    typedef struct packed {
        logic [1:0]         mode;
        logic               sgn;
        logic [SUM_W-1:0]   s;
        logic [CARRY_W-1:0] carry;
    } word_t;

    function automatic int lane_width(input logic [1:0] mode);
        return LANE_W_TAB[mode];
    endfunction

    function automatic int lane_count(input logic [1:0] mode);
        return LANE_N_TAB[mode];
    endfunction

endpackage

// File: rtl/mac_unpack_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is visible on rd_data
// whenever the FIFO is non-empty.
module mac_unpack_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is data only; a push into a slot freed by a same-cycle pop is safe
    // because the head was already read combinationally.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mac_result_unpacker.sv
// Splits buffered overlay sum words into per-lane results, one lane per cycle.
// Optional counters enabled by defining MAC_UNPACK_STATS_EN.
module mac_result_unpacker
    import mac_overlay_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OUT_W = 54
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic               in_signed,
    input  logic [SUM_W-1:0]   in_s,
    input  logic [CARRY_W-1:0] in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_carry,
    output logic [1:0]         out_lane,
    output logic               out_last,
    output logic               mode_err
`ifdef MAC_UNPACK_STATS_EN
   ,output logic [31:0]        stat_words,
    output logic [31:0]        stat_lanes,
    output logic [31:0]        stat_err
`endif
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state;
    state_t     state_nx;
    word_t      wr_word;
    word_t      head;
    word_t      hold;
    logic [1:0] lane;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       last;

    // Lane is shifted to the top then shifted back, arithmetically when signed.
    function automatic logic [OUT_W-1:0] extend_lane(input logic [SUM_W-1:0] s,
                                                     input int w,
                                                     input logic [1:0] idx,
                                                     input logic sgn);
        logic        [OUT_W-1:0] raw;
        logic signed [OUT_W-1:0] sx;
        int                      pad;
        pad = OUT_W - w;
        raw = OUT_W'(s >> (int'(idx) * w)) << pad;
        sx  = signed'(raw);
        return sgn ? OUT_W'(sx >>> pad) : (raw >> pad);
    endfunction

    assign wr_word  = '{mode: in_mode, sgn: in_signed, s: in_s, carry: in_carry};
    assign in_ready = !full || pop;
    assign push     = in_valid && in_ready;

    mac_unpack_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(word_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_word),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign last = (lane == 2'(lane_count(hold.mode) - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (out_ready && last) begin
                    if (!empty) pop      = 1'b1;
                    else        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Holding register: changes only on a load or an accepted lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold     <= '0;
            lane     <= '0;
            mode_err <= 1'b0;
        end else begin
            mode_err <= pop && (head.mode == MODE_RSVD);
            if (pop) begin
                hold <= head;
                lane <= '0;
            end else if ((state == EMIT) && out_ready && !last) begin
                lane <= lane + 2'd1;
            end
        end
    end

    assign out_valid = (state == EMIT);
    assign out_lane  = lane;
    assign out_last  = out_valid && last;
    assign out_carry = hold.carry[lane];
    assign out_data  = extend_lane(hold.s, lane_width(hold.mode), lane, hold.sgn);

`ifdef MAC_UNPACK_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_words <= '0;
            stat_lanes <= '0;
            stat_err   <= '0;
        end else begin
            if (pop)                              stat_words <= sat_inc(stat_words);
            if (out_valid && out_ready)           stat_lanes <= sat_inc(stat_lanes);
            if (pop && (head.mode == MODE_RSVD))  stat_err   <= sat_inc(stat_err);
        end
    end
`endif

endmodule

// File: doc/mac_result_unpacker.md
Name: mac_result_unpacker

Overview:
- Consumer-side block for the C3x3 27x27 SIMD MAC overlay.
- Takes each registered 54-bit sum word plus its 24-bit SIMD carry vector, buffers it in a small FIFO, and splits it by SIMD mode into per-lane results.
- Lanes are emitted one per cycle over a valid/ready stream to downstream writeback or accumulation logic.

Parameters:
- DEPTH, 4: input FIFO depth in words; power of two, ≥2.
- OUT_W, 54: output lane data width; lanes are sign- or zero-extended to this width.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  FIFO can accept a word.
- in_mode  in  2  SIMD mode of the word.
- in_signed  in  1  lanes are signed (sign-extend) when 1.
- in_s  in  54  overlay sum word.
- in_carry  in  24  overlay SIMD carry vector.
- out_valid  out  1  lane result present.
- out_ready  in  1  downstream accepts the lane.
- out_data  out  OUT_W  extended lane value.
- out_carry  out  1  carry bit of this lane.
- out_lane  out  2  lane index.
- out_last  out  1  final lane of the word.
- mode_err  out  1  one-cycle pulse when a reserved-mode word is popped.

Behaviour:
- Reset (async assert, sync release): FIFO empty; state IDLE; out_valid=0, out_data=0, out_carry=0, out_lane=0, out_last=0, mode_err=0; in_ready=1 after release.
- Input handshake: a word is pushed when in_valid && in_ready. in_ready = !full.
- Simultaneous push and pop when full is legal: the pop frees the slot in the same cycle, so in_ready = !full || pop_this_cycle.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Empty/full are determined by comparing the MSBs.
- Lane map by mode:
  - 0: 1 lane, bits [53:0], carry = in_carry[0].
  - 1: 2 lanes of 27 bits, [26:0] and [53:27], carries in_carry[0] and in_carry[1].
  - 2: 3 lanes of 18 bits, [17:0], [35:18], [53:36], carries in_carry[2:0].
  - 3: reserved. Handled as mode 0, and mode_err pulses on pop.
- Lane 0 is always the least-significant lane.
- Extension: the lane MSB is replicated to OUT_W when in_signed=1; otherwise the lane is zero-filled.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head into a holding register, set lane=0, go to EMIT. out_valid rises the cycle after the pop, so the first lane of an already-buffered word appears 2 cycles after the push.
  - EMIT: out_valid=1. Outputs hold stable while !out_ready. On out_ready:
    - not last lane: lane++.
    - last lane and FIFO non-empty: pop the next word, lane=0, stay in EMIT. This gives back-to-back words with no bubble.
    - last lane and FIFO empty: go to IDLE, out_valid=0.
- out_last = (lane == nlanes-1).
- The output register updates only on handshake or load; it never changes while out_valid && !out_ready.
- Throughput: one lane per cycle, so a mode-2 word occupies 3 output cycles.
- Reset mid-word: the word is discarded, FIFO contents are lost, and all outputs return to their reset values immediately.

Optional Feature:
- Macro MAC_UNPACK_STATS_EN.
- When defined, three 32-bit output ports are added:
  - stat_words: words popped.
  - stat_lanes: lanes handshaken.
  - stat_err: reserved-mode words.
- All three saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mac_overlay_pkg holds:
  - constants for mode encodings MODE_W54=0, MODE_2X27=1, MODE_3X18=2, MODE_RSVD=3.
  - SUM_W=54, CARRY_W=24.
  - the per-mode lane width and lane count tables.
- One sub-module, mac_unpack_fifo: a parameterised synchronous FIFO with push/pop/full/empty. The FSM and lane mux stay in the top module.

Test Plan:
- Mode 0, signed, in_s=54'h20000000000000, in_carry=1 -> one lane: out_data=54'h20000000000000, out_carry=1, out_last=1, out_lane=0.
- Mode 1, signed, in_s={27'h4000000, 27'h0000005}, in_carry=2'b10 -> lane0 data=5, carry=0; lane1 data=0x3FFFFFFC000000 (sign-extended), carry=1, last=1.
- Mode 2, unsigned, in_s={18'h3FFFF, 18'h00001, 18'h00002} -> lanes 2, 1, 0x3FFFF in order, all zero-extended. Then hold out_ready=0 for 5 cycles mid-word -> outputs stable, no lane skipped.
- Push 6 mode-2 words back-to-back with out_ready=1 and DEPTH=4 -> in_ready drops while full. 18 consecutive out_valid cycles with no bubble; first lane appears 2 cycles after the first push.
- Mode 3 word -> single 54-bit lane, mode_err=1 for exactly one cycle. With MAC_UNPACK_STATS_EN, stat_err=1.
- Assert reset during lane 1 of a mode-2 word with 2 words buffered -> outputs zero immediately. After release, in_ready=1 and no stale lanes emerge.
